// File: rtl/vce_pkg.sv
// Shared constants and types for the HuC6260 video colour encoder:
// CPU register map, dot-divider encodings and palette word layout.
package vce_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_CTA_LO = 3'd2;
    localparam logic [2:0] REG_CTA_HI = 3'd3;
    localparam logic [2:0] REG_CTD_LO = 3'd4;
    localparam logic [2:0] REG_CTD_HI = 3'd5;

    // control[1:0]: 00 -> /4, 01 -> /3, 1x -> /2
    localparam logic [1:0] DIV_SEL_4 = 2'b00;
    localparam logic [1:0] DIV_SEL_3 = 2'b01;
    localparam logic [2:0] DIV_N_4   = 3'd4;
    localparam logic [2:0] DIV_N_3   = 3'd3;
    localparam logic [2:0] DIV_N_2   = 3'd2;

    localparam int G_HI = 8;
    localparam int G_LO = 6;
    localparam int R_HI = 5;
    localparam int R_LO = 3;
    localparam int B_HI = 2;
    localparam int B_LO = 0;

    typedef logic [8:0] pal_word_t;

    function automatic logic [2:0] div_n(input logic [1:0] sel);
        if (sel == DIV_SEL_4) return DIV_N_4;
        if (sel == DIV_SEL_3) return DIV_N_3;
        return DIV_N_2;
    endfunction

endpackage

// File: rtl/vce_huc6260_if.sv
// CPU register-port strobes and address of the colour encoder.
interface vce_huc6260_if;
    logic [2:0] A;
    logic       CS_n;
    logic       RD_n;
    logic       WR_n;

    modport master (output A, CS_n, RD_n, WR_n);
    modport slave  (input  A, CS_n, RD_n, WR_n);
endinterface

// File: rtl/vce_dot_clock_div.sv
// Dot-clock enable generator: one-cycle CK pulse every N clocks, where N
// is only re-sampled from the select input when the counter wraps.
module vce_dot_clock_div
    import vce_pkg::*;
(
    input  logic       clock,
    input  logic       reset_N,
    input  logic [1:0] sel,
    output logic       ck
);

    logic [2:0] cnt_q, cnt_d;
    logic [2:0] n_q, n_d;

    always_comb begin
        ck    = (cnt_q == n_q - 3'd1);
        cnt_d = cnt_q + 3'd1;
        n_d   = n_q;
        if (ck) begin
            cnt_d = '0;
            n_d   = div_n(sel);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            cnt_q <= '0;
            n_q   <= DIV_N_4;
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
        end
    end

endmodule

// File: rtl/vce_huc6260.sv
// HuC6260 video colour encoder: palette lookup of VDC pixel codes into
// 3:3:3 RGB, dot-clock pacing and the CPU colour-table register port.
module vce_huc6260
    import vce_pkg::*;
#(
    parameter int PAL_DEPTH = 512,
    parameter int CHAN_W    = 3
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic [8:0]        VD,
    input  logic              HSYN,
    input  logic              VSYN,
    vce_huc6260_if.slave      cpu,
    inout  wire  [8:0]        D,
    output logic              CK,
    output logic [1:0]        address_mode,
    output logic [CHAN_W-1:0] VIDEO_R,
    output logic [CHAN_W-1:0] VIDEO_G,
    output logic [CHAN_W-1:0] VIDEO_B
);

    localparam int AW = $clog2(PAL_DEPTH);

    logic [7:0]    control_q, control_d;
    logic [AW-1:0] cta_q, cta_d;
    logic          wr_prev_q, wr_prev_d;
    logic          rd_prev_q, rd_prev_d;
    pal_word_t     pix_q, pix_d;

    logic          wr_act, rd_act, wr_stb, rd_stb;
    logic          pal_we_lo, pal_we_hi;
    logic [AW-1:0] lut_idx;
    pal_word_t     lut_data, cta_data;
    logic [8:0]    d_out;
    pal_word_t     pal_mem [PAL_DEPTH];
    logic          unused_bits;

    vce_dot_clock_div u_div (
        .clock   (clock),
        .reset_N (reset_N),
        .sel     (control_q[1:0]),
        .ck      (CK)
    );

    // Entries power up as the identity map and are never touched by reset.
    for (genvar i = 0; i < PAL_DEPTH; i++) begin : g_pal
        pal_word_t ent_q = pal_word_t'(i);
        pal_word_t ent_d;
        always_comb begin
            ent_d = ent_q;
            if (pal_we_lo && cta_q == AW'(i)) ent_d[7:0] = D[7:0];
            if (pal_we_hi && cta_q == AW'(i)) ent_d[8]   = D[0];
        end
        always_ff @(posedge clock) ent_q <= ent_d;
        assign pal_mem[i] = ent_q;
    end

    always_comb begin
        wr_act    = !cpu.CS_n && !cpu.WR_n;
        rd_act    = !cpu.CS_n && !cpu.RD_n && cpu.WR_n;
        wr_stb    = wr_act && !wr_prev_q && reset_N;
        rd_stb    = rd_act && !rd_prev_q && reset_N;
        wr_prev_d = wr_act;
        rd_prev_d = rd_act;
        control_d = control_q;
        cta_d     = cta_q;
        pal_we_lo = 1'b0;
        pal_we_hi = 1'b0;
        if (wr_stb) begin
            case (cpu.A)
                REG_CTRL:   control_d     = D[7:0];
                REG_CTA_LO: cta_d[7:0]    = D[7:0];
                REG_CTA_HI: cta_d[AW-1]   = D[0];
                REG_CTD_LO: pal_we_lo     = 1'b1;
                REG_CTD_HI: begin
                    pal_we_hi = 1'b1;
                    cta_d     = cta_q + AW'(1);
                end
                default: ;
            endcase
        end
        if (rd_stb && cpu.A == REG_CTD_HI) cta_d = cta_q + AW'(1);
    end

    // Lookup uses the pre-edge palette, so a same-cycle write is not seen.
    always_comb begin
        lut_idx  = (VD[3:0] == 4'h0) ? '0 : VD[AW-1:0];
        lut_data = pal_mem[lut_idx];
        cta_data = pal_mem[cta_q];
        pix_d    = pix_q;
        if (CK) pix_d = (!HSYN || !VSYN) ? '0 : lut_data;
    end

    always_comb begin
        case (cpu.A)
            REG_CTD_LO: d_out = {1'b0, cta_data[7:0]};
            REG_CTD_HI: d_out = {1'b0, 7'h7F, cta_data[8]};
            default:    d_out = 9'h0FF;
        endcase
    end

    assign D            = rd_act ? d_out : 'z;
    assign address_mode = control_q[1:0];
    assign VIDEO_G      = pix_q[G_HI:G_LO];
    assign VIDEO_R      = pix_q[R_HI:R_LO];
    assign VIDEO_B      = pix_q[B_HI:B_LO];
    assign unused_bits  = ^{control_q[7:2], D[8]};

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            control_q <= '0;
            cta_q     <= '0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            control_q <= control_d;
            cta_q     <= cta_d;
            wr_prev_q <= wr_prev_d;
            rd_prev_q <= rd_prev_d;
            pix_q     <= pix_d;
        end
    end

endmodule

// File: tb/tb_vce_huc6260.sv
// Self-checking bench for vce_huc6260: directed register/pixel scenarios
// followed by randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_vce_huc6260;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] VD;
    logic       HSYN, VSYN;
    logic [8:0] tb_d;
    logic       tb_oe;
    wire  [8:0] D;
    logic       CK;
    logic [1:0] amode;
    logic [2:0] vr, vg, vb;
    logic       rnd;
    logic       mon_on;

    int n_chk  = 0;
    int n_fail = 0;

    vce_huc6260_if bus ();

    assign D = tb_oe ? tb_d : 'z;
    for (genvar i = 0; i < 9; i++) begin : g_pu
        pullup (D[i]);
    end

    always #5 clk = ~clk;

    vce_huc6260 dut (
        .clock        (clk),
        .reset_N      (rst_n),
        .VD           (VD),
        .HSYN         (HSYN),
        .VSYN         (VSYN),
        .cpu          (bus),
        .D            (D),
        .CK           (CK),
        .address_mode (amode),
        .VIDEO_R      (vr),
        .VIDEO_G      (vg),
        .VIDEO_B      (vb)
    );

    // Reference model state: register file, palette and period tracking.
    logic [7:0] m_ctrl;
    logic [8:0] m_cta;
    logic [8:0] m_pal [512];
    logic [8:0] m_rgb;
    logic       m_ck;
    int         m_since, m_gap;
    logic       m_wprev, m_rprev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input logic [7:0] c);
        return c[1] ? 2 : (c[0] ? 3 : 4);
    endfunction

    function automatic logic [8:0] rd_exp(input logic [2:0] a);
        if (a == 3'd4) return {1'b0, m_pal[m_cta][7:0]};
        if (a == 3'd5) return {1'b0, 7'h7F, m_pal[m_cta][8]};
        return 9'h0FF;
    endfunction

    task automatic model_edge();
        logic       wr, rd;
        logic [8:0] idx;
        wr = !bus.CS_n && !bus.WR_n;
        rd = !bus.CS_n && !bus.RD_n && bus.WR_n;
        if (!rst_n) begin
            m_ctrl = 8'h00; m_cta = 9'h000; m_rgb = 9'h000;
            m_wprev = 1'b0; m_rprev = 1'b0; m_since = 1; m_gap = 4;
        end else begin
            if (m_ck) begin
                idx     = (VD[3:0] == 4'h0) ? 9'h000 : VD;
                m_rgb   = (!HSYN || !VSYN) ? 9'h000 : m_pal[idx];
                m_gap   = n_of(m_ctrl);
                m_since = 1;
            end else begin
                m_since++;
            end
            if (wr && !m_wprev) begin
                case (bus.A)
                    3'd0: m_ctrl = tb_d[7:0];
                    3'd2: m_cta[7:0] = tb_d[7:0];
                    3'd3: m_cta[8] = tb_d[0];
                    3'd4: m_pal[m_cta][7:0] = tb_d[7:0];
                    3'd5: begin m_pal[m_cta][8] = tb_d[0]; m_cta = m_cta + 9'd1; end
                    default: ;
                endcase
            end
            if (rd && !m_rprev && bus.A == 3'd5) m_cta = m_cta + 9'd1;
            m_wprev = wr;
            m_rprev = rd;
        end
        m_ck = (m_since == m_gap);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("ck", CK, m_ck);
            chk("address_mode", amode, m_ctrl[1:0]);
            chk("rgb", {vg, vr, vb}, m_rgb);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        if (rnd) begin
            VD   = 9'($urandom);
            HSYN = ($urandom_range(0, 7) != 0);
            VSYN = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d, input int hold = 1);
        bus.A = a; tb_d = {1'b0, d}; tb_oe = 1'b1;
        bus.CS_n = 1'b0; bus.WR_n = 1'b0;
        repeat (hold) step();
        bus.CS_n = 1'b1; bus.WR_n = 1'b1; tb_oe = 1'b0;
        step();
    endtask

    task automatic cpu_read(input string tag, input logic [2:0] a, input logic [8:0] exp, input int hold = 1);
        bus.A = a; bus.CS_n = 1'b0; bus.RD_n = 1'b0;
        #1 chk(tag, D, exp);
        repeat (hold) step();
        bus.CS_n = 1'b1; bus.RD_n = 1'b1;
        step();
    endtask

    task automatic pix_check(input string tag, input logic [8:0] vd, input logic hs, input logic vs,
                             input logic [8:0] exp);
        bit seen;
        seen = 1'b0;
        VD = vd; HSYN = hs; VSYN = vs;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (m_ck) seen = 1'b1;
            @(negedge clk);
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        else       chk(tag, {vg, vr, vb}, exp);
    endtask

    task automatic measure_period(input string tag, input int exp);
        int k, cnt;
        k = 0;
        while (CK !== 1'b1 && k < 16) begin step(); k++; end
        cnt = 0;
        do begin step(); cnt++; end while (CK !== 1'b1 && cnt < 16);
        chk(tag, cnt, exp);
    endtask

    initial begin
        rst_n = 1'b0; VD = 9'h000; HSYN = 1'b1; VSYN = 1'b1;
        bus.A = 3'd0; bus.CS_n = 1'b1; bus.RD_n = 1'b1; bus.WR_n = 1'b1;
        tb_oe = 1'b0; tb_d = 9'h000; rnd = 1'b0; mon_on = 1'b0;
        m_ck = 1'b0; m_rgb = 9'h000; m_ctrl = 8'h00; m_cta = 9'h000;
        m_since = 1; m_gap = 4; m_wprev = 1'b0; m_rprev = 1'b0;
        for (int i = 0; i < 512; i++) m_pal[i] = 9'(i);

        repeat (3) @(negedge clk);
        chk("rst_ck", CK, 0);
        chk("rst_rgb", {vg, vr, vb}, 0);
        chk("rst_mode", amode, 0);
        rst_n = 1'b1; mon_on = 1'b1;

        pix_check("vd012", 9'h012, 1'b1, 1'b1, {3'd0, 3'd2, 3'd2});
        measure_period("period_div4", 4);

        cpu_write(3'd0, 8'h01);
        chk("mode_1", amode, 1);
        measure_period("period_div3", 3);
        cpu_write(3'd0, 8'h02);
        chk("mode_2", amode, 2);
        measure_period("period_div2", 2);
        cpu_write(3'd0, 8'h83);
        measure_period("period_div2_m3", 2);
        cpu_write(3'd0, 8'h00);
        measure_period("period_back4", 4);

        cpu_write(3'd2, 8'h05); cpu_write(3'd3, 8'h01);
        cpu_write(3'd4, 8'hC7); cpu_write(3'd5, 8'h01);
        cpu_read("cta_incr", 3'd4, 9'h006);
        pix_check("vd105", 9'h105, 1'b1, 1'b1, {3'd7, 3'd0, 3'd7});

        cpu_write(3'd2, 8'h00); cpu_write(3'd3, 8'h00);
        cpu_write(3'd4, 8'hA5); cpu_write(3'd5, 8'h00);
        pix_check("vd110_nib0", 9'h110, 1'b1, 1'b1, {3'd2, 3'd4, 3'd5});

        pix_check("hsyn_low", 9'h105, 1'b0, 1'b1, 9'h000);
        pix_check("sync_back", 9'h105, 1'b1, 1'b1, {3'd7, 3'd0, 3'd7});
        pix_check("vsyn_low", 9'h105, 1'b1, 1'b0, 9'h000);

        cpu_write(3'd2, 8'hFF); cpu_write(3'd3, 8'h01);
        cpu_write(3'd4, 8'h3C); cpu_write(3'd5, 8'h00);
        cpu_read("wr_wrap", 3'd4, 9'h0A5);
        cpu_write(3'd2, 8'hFF); cpu_write(3'd3, 8'h01);
        cpu_read("rd_lo", 3'd4, 9'h03C);
        cpu_read("rd_hi", 3'd5, 9'h0FE);
        cpu_read("rd_wrap", 3'd4, 9'h0A5);
        cpu_read("rd_hi0", 3'd5, 9'h0FE);
        cpu_read("rd_other", 3'd1, 9'h0FF);
        cpu_read("rd_ctrl", 3'd0, 9'h0FF);
        #1 chk("d_idle_z", D, 9'h1FF);
        cpu_read("rd_hold", 3'd5, 9'h0FE, 4);
        cpu_read("after_hold_rd", 3'd4, 9'h002);
        cpu_write(3'd5, 8'h01, 3);
        cpu_read("after_hold_wr", 3'd4, 9'h003);

        // Palette write lands on the same edge that samples that entry.
        cpu_write(3'd2, 8'h33); cpu_write(3'd3, 8'h00);
        VD = 9'h033; HSYN = 1'b1; VSYN = 1'b1;
        for (int k = 0; k < 8 && !m_ck; k++) step();
        chk("rbw_ck_seen", m_ck, 1);
        bus.A = 3'd4; tb_d = 9'h0FF; tb_oe = 1'b1; bus.CS_n = 1'b0; bus.WR_n = 1'b0;
        step();
        chk("rbw_old", {vg, vr, vb}, 9'h033);
        bus.CS_n = 1'b1; bus.WR_n = 1'b1; tb_oe = 1'b0;
        step();
        pix_check("rbw_new", 9'h033, 1'b1, 1'b1, 9'h0FF);

        cpu_write(3'd0, 8'h02);
        bus.A = 3'd4; tb_d = 9'h05A; tb_oe = 1'b1; bus.CS_n = 1'b0; bus.WR_n = 1'b0;
        rst_n = 1'b0;
        step(); step();
        chk("rst_mid_mode", amode, 0);
        rst_n = 1'b1;
        step(); step();
        bus.CS_n = 1'b1; bus.WR_n = 1'b1; tb_oe = 1'b0;
        step();
        cpu_read("rst_strobe", 3'd4, 9'h05A);

        rnd = 1'b1;
        repeat (400) begin
            case ($urandom_range(0, 5))
                0: cpu_write(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(1, 3));
                1: cpu_write(3'($urandom_range(4, 5)), 8'($urandom));
                2: begin
                    logic [2:0] a;
                    a = 3'($urandom_range(0, 7));
                    cpu_read("rnd_rd", a, rd_exp(a), $urandom_range(1, 2));
                end
                default: repeat ($urandom_range(1, 6)) step();
            endcase
        end
        rnd = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vce_huc6260.md
Name: vce_huc6260

Overview:
- Video Color Encoder: takes the 9-bit pixel code VD and the active-low syncs from the VDC, looks each pixel up in a 512-entry × 9-bit palette, and drives 3:3:3 RGB.
- Generates the dot-clock enable CK that paces the VDC.
- Provides a CPU register port for the divider mode and for palette (color table) access.
- Sits between the VDC and the video DAC/log path.

Parameters:
- PAL_DEPTH, 512, palette entries (address width 9).
- CHAN_W, 3, bits per color channel.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_N  in  1  reset; synchronous and active-low.
- VD  in  9  pixel code from the VDC; bit8 = sprite palette half.
- HSYN  in  1  horizontal sync from the VDC, active low.
- VSYN  in  1  vertical sync from the VDC, active low.
- A  in  3  CPU register address.
- D  inout  9  CPU data; bits[7:0] significant; bit8 driven 0 on reads, ignored on writes.
- CS_n, RD_n, WR_n  in  1 each  CPU strobes, active low.
- CK  out  1  dot-clock enable, one-cycle pulse per pixel.
- address_mode  out  2  current dot-clock select (control[1:0]).
- VIDEO_R, VIDEO_G, VIDEO_B  out  3 each  color outputs.

Behaviour:
- Reset (reset_N=0 at clock edge):
  - control=0 (divide-by-4), CTA=0, divider counter=0.
  - CK=0, VIDEO_R/G/B=0, address_mode=0.
  - Palette RAM is not cleared. It is initialised at elaboration to entry i = i.
- Dot divider:
  - control[1:0] selects N: 00→4, 01→3, 1x→2.
  - Counter counts 0..N-1; CK=1 exactly in the cycle the counter equals N-1, then it wraps to 0.
  - A new N is latched only at wrap, so there are no short or long glitch periods.
- Pixel path:
  - On an edge where CK=1: if HSYN=0 or VSYN=0, RGB registers load 0.
  - Otherwise, idx = (VD[3:0]==0) ? 9'h000 : VD; the registers load palette[idx].
  - Palette word format is GRB: G=[8:6], R=[5:3], B=[2:0].
  - RGB holds between CK pulses. Latency is one clock from the CK-qualified VD sample to the output.
- CPU writes:
  - Accepted on the first cycle where CS_n=0 && WR_n=0, i.e. the falling edge of (CS_n|WR_n). Each strobe yields one write even if held.
  - A=0: control ← D[7:0] (bits[1:0] used; bit7 stored).
  - A=2: CTA[7:0] ← D[7:0]. A=3: CTA[8] ← D[0].
  - A=4: palette[CTA][7:0] ← D[7:0].
  - A=5: palette[CTA][8] ← D[0], then CTA ← CTA+1 (511 wraps to 0).
  - A=1, 6 and 7 are ignored.
- CPU reads:
  - D is driven combinationally while CS_n=0 && RD_n=0 && WR_n=1; otherwise D is Z.
  - A=4 returns {1'b0, palette[CTA][7:0]}.
  - A=5 returns {1'b0, 7'h7F, palette[CTA][8]}; CTA increments on the read strobe's first cycle.
  - All other addresses return 9'h0FF.
- Simultaneous events:
  - A palette write and a pixel lookup of the same entry in one cycle: the lookup returns the old value (read-before-write).
  - Reset asserted mid-operation aborts any pending strobe. The first strobe after reset is treated as a new edge.

Decomposition:
- Package vce_pkg holds:
  - register address constants (REG_CTRL=0, REG_CTA_LO=2, REG_CTA_HI=3, REG_CTD_LO=4, REG_CTD_HI=5);
  - divider encodings and their N values;
  - GRB field slice localparams;
  - typedef for the 9-bit palette word.
- One sub-module, vce_dot_clock_div, contains the counter, N-latching and CK generation.
- The palette is an inferred RAM inside the top.

Test Plan:
- Reset, no CPU access, mode /4: CK pulses every 4th clock. With VD=9'h012 and syncs high, outputs are G=0, R=2, B=2, updated 1 clock after the CK edge.
- Write control=1, then 2: CK period changes to 3, then 2, only after the current period completes. address_mode tracks the change.
- CTA=0x105 (A2=0x05, A3=0x01), A4=0xC7, A5=0x01: palette[0x105]=0x1C7 and CTA becomes 0x106. A later VD=0x105 gives G=7, R=0, B=7.
- VD=9'h110 (low nibble 0): the output uses palette[0], not palette[0x110].
- HSYN=0 or VSYN=0 with any VD: RGB=0 at the next CK sample.
- Read back: set CTA=0x1FF, then read A4 and A5. D returns the low byte and {7'h7F, bit8}, CTA wraps to 0, and D is Z when CS_n=1.
